// File: rtl/fgpr_read_arbiter_pkg.sv
// prv664_fgpr_pkg: FP register index types shared by the read arbiter files.
`ifndef XLEN
`define XLEN 64
`endif
package prv664_fgpr_pkg;

    localparam int FGPR_IDX_W = 5;

    typedef logic [FGPR_IDX_W-1:0] fgpr_idx_t;

    typedef struct packed {
        logic      valid;
        fgpr_idx_t index;
    } fgpr_rd_req_t;

    function automatic int clog2_1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fgpr_read_arbiter_if.sv
// fgpr_read_arbiter_if: channel request/response, rf read-port and writeback signals.
interface fgpr_read_arbiter_if
    import prv664_fgpr_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int NPORT = 2,
    parameter int DW    = `XLEN
);
    logic [NCH-1:0]            req_valid_i;
    fgpr_idx_t [NCH-1:0]       req_index_i;
    logic [NCH-1:0]            req_ready_o;
    logic [NCH-1:0]            rsp_valid_o;
    logic [NCH-1:0][DW-1:0]    rsp_data_o;
    logic [NPORT-1:0]          rf_valid_o;
    fgpr_idx_t [NPORT-1:0]     rf_index_o;
    logic [NPORT-1:0][DW-1:0]  rf_data_i;
    logic                      wb_valid_i;
    fgpr_idx_t                 wb_index_i;
    logic [DW-1:0]             wb_data_i;

    modport slave (
        input  req_valid_i, req_index_i, rf_data_i, wb_valid_i, wb_index_i, wb_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rf_valid_o, rf_index_o
    );

    modport master (
        output req_valid_i, req_index_i, rf_data_i, wb_valid_i, wb_index_i, wb_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rf_valid_o, rf_index_o
    );
endinterface

// File: rtl/fgpr_read_arbiter_rr_pick.sv
// rr_pick: first set bit of req_i scanning upward from ptr_i with wraparound.
module rr_pick
    import prv664_fgpr_pkg::*;
#(
    parameter int W  = 3,
    parameter int PW = clog2_1(W)
) (
    input  logic [W-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          vld_o,
    output logic [PW-1:0] idx_o
);
    // Scanning from the far end lets the nearest request overwrite the result.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        for (int k = W - 1; k >= 0; k--) begin
            int c;
            c = int'(ptr_i) + k;
            if (c >= W) c = c - W;
            if (req_i[c]) begin
                vld_o = 1'b1;
                idx_o = PW'(c);
            end
        end
    end
endmodule

// File: rtl/fgpr_read_arbiter.sv
// fgpr_read_arbiter: round-robin, index-merging arbiter of NCH FP read channels onto NPORT rf ports.
// Define FGPR_RD_BYPASS_EN to forward a same-cycle writeback into the captured response.
module fgpr_read_arbiter
    import prv664_fgpr_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int NPORT = 2,
    parameter int DW    = `XLEN
) (
    input logic                clk_i,
    input logic                srst_i,
    fgpr_read_arbiter_if.slave bus
);
    localparam int PW = clog2_1(NCH);
    localparam int QW = clog2_1(NPORT);

    fgpr_rd_req_t [NCH-1:0]    req;
    logic [NCH-1:0]            valid_v;
    logic [NPORT-1:0][NCH-1:0] hit;
    logic [NPORT-1:0]          pick_vld;
    logic [NPORT-1:0][PW-1:0]  pick_ch;
    fgpr_idx_t [NPORT-1:0]     pick_idx;
    logic [NPORT-1:0][DW-1:0]  port_data;
    logic [NCH-1:0]            rem_last;
    logic [NCH-1:0]            gnt;
    logic [NCH-1:0][QW-1:0]    port_of;
    logic [PW-1:0]             last_ch;
    logic [PW-1:0]             rr_ptr_d, rr_ptr_q;
    logic [NCH-1:0]            rsp_valid_d, rsp_valid_q;
    logic [NCH-1:0][DW-1:0]    rsp_data_d, rsp_data_q;

    always_comb begin
        req     = '0;
        valid_v = '0;
        for (int c = 0; c < NCH; c++) begin
            req[c]     = '{valid: bus.req_valid_i[c], index: bus.req_index_i[c]};
            valid_v[c] = req[c].valid;
        end
    end

    // Each port takes the next unserved channel in rr order, then absorbs every channel reading the same index.
    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic [NCH-1:0] rem_in, rem_out, hit_v;
        if (p == 0) begin : g_first
            assign rem_in = valid_v;
        end else begin : g_next
            assign rem_in = g_port[p-1].rem_out;
        end
        rr_pick #(.W(NCH), .PW(PW)) u_pick (
            .req_i (rem_in),
            .ptr_i (rr_ptr_q),
            .vld_o (pick_vld[p]),
            .idx_o (pick_ch[p])
        );
        assign pick_idx[p] = req[pick_ch[p]].index;
        always_comb begin
            hit_v = '0;
            for (int c = 0; c < NCH; c++)
                hit_v[c] = rem_in[c] & pick_vld[p] & (req[c].index == pick_idx[p]);
        end
        assign rem_out = rem_in & ~hit_v;
        assign hit[p]  = hit_v;
`ifdef FGPR_RD_BYPASS_EN
        assign port_data[p] = (bus.wb_valid_i && bus.wb_index_i == pick_idx[p]) ? bus.wb_data_i
                                                                                  : bus.rf_data_i[p];
`else
        assign port_data[p] = bus.rf_data_i[p];
`endif
    end

`ifndef FGPR_RD_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{bus.wb_valid_i, bus.wb_index_i, bus.wb_data_i};
`endif

    assign rem_last = g_port[NPORT-1].rem_out;

    always_comb begin
        gnt     = valid_v & ~rem_last;
        port_of = '0;
        for (int p = 0; p < NPORT; p++)
            for (int c = 0; c < NCH; c++)
                if (hit[p][c]) port_of[c] = QW'(p);
        last_ch = '0;
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = int'(rr_ptr_q) + k;
            if (c >= NCH) c = c - NCH;
            if (gnt[c]) last_ch = PW'(c);
        end
        rr_ptr_d    = srst_i ? '0 :
                      |(valid_v & ~gnt) ? ((last_ch == PW'(NCH - 1)) ? '0 : last_ch + 1'b1) :
                      rr_ptr_q;
        rsp_valid_d = srst_i ? '0 : gnt;
        rsp_data_d  = '0;
        for (int c = 0; c < NCH; c++)
            rsp_data_d[c] = srst_i ? '0 : gnt[c] ? port_data[port_of[c]] : rsp_data_q[c];
    end

    always_ff @(posedge clk_i) begin
        rr_ptr_q    <= rr_ptr_d;
        rsp_valid_q <= rsp_valid_d;
        rsp_data_q  <= rsp_data_d;
    end

    always_comb begin
        bus.rf_valid_o = '0;
        bus.rf_index_o = '0;
        for (int p = 0; p < NPORT; p++) begin
            bus.rf_valid_o[p] = pick_vld[p] & ~srst_i;
            bus.rf_index_o[p] = bus.rf_valid_o[p] ? pick_idx[p] : '0;
        end
    end

    // A response registered just before reset is dropped in the reset cycle itself.
    assign bus.req_ready_o = srst_i ? '0 : gnt;
    assign bus.rsp_valid_o = rsp_valid_q & ~{NCH{srst_i}};
    assign bus.rsp_data_o  = rsp_data_q;
endmodule
